// File: rtl/bq_pkg.sv
// Shared defaults and the pointer-wrap helper for bounded_queue_fifo.
package bq_pkg;

    localparam int BQ_DATA_W = 8;
    localparam int BQ_DEPTH  = 11;

    // Wrap explicitly at depth-1 so non-power-of-two depths stay in range.
    function automatic logic [31:0] next_ptr(input logic [31:0] ptr, input int unsigned depth);
        return (ptr == 32'(depth - 1)) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/bounded_queue_fifo_if.sv
// Push/pop handshake bundle for bounded_queue_fifo; master is the producer/consumer side.
interface bounded_queue_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 11
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              clear;
    logic              push_valid;
    logic              push_ready;
    logic [DATA_W-1:0] push_data;
    logic              pop_valid;
    logic              pop_ready;
    logic [DATA_W-1:0] pop_data;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              overflow;

    modport master (
        output clear, push_valid, push_data, pop_ready,
        input  push_ready, pop_valid, pop_data, count, full, empty, overflow
    );

    modport slave (
        input  clear, push_valid, push_data, pop_ready,
        output push_ready, pop_valid, pop_data, count, full, empty, overflow
    );
endinterface

// File: rtl/bq_storage.sv
// DEPTH x DATA_W register array: one synchronous write port, one async read port, no reset.
module bq_storage #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 11,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [PTR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wr_addr] = wr_data;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/bounded_queue_fifo.sv
// First-word-fall-through bounded queue with occupancy count and sticky overflow.
// Define BQ_DROP_OLDEST_EN to accept pushes when full by discarding the oldest entry.
module bounded_queue_fifo
    import bq_pkg::*;
#(
    parameter int DATA_W = BQ_DATA_W,
    parameter int DEPTH  = BQ_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH + 1),
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    bounded_queue_fifo_if.slave bus
);
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic             full, empty, push_ready, pop_valid;
    logic             push_fire, pop_fire, wr_en;
    logic [PTR_W-1:0] wr_ptr_nxt, rd_ptr_nxt;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // Ready depends only on registered occupancy, never on pop_ready.
`ifdef BQ_DROP_OLDEST_EN
    assign push_ready = 1'b1;
`else
    assign push_ready = !full;
`endif
    assign pop_valid = !empty;

    assign push_fire = bus.push_valid & push_ready;
    assign pop_fire  = pop_valid & bus.pop_ready;

    assign wr_ptr_nxt = PTR_W'(next_ptr(32'(wr_ptr_q), DEPTH));
    assign rd_ptr_nxt = PTR_W'(next_ptr(32'(rd_ptr_q), DEPTH));

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        if (bus.clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            wr_en = push_fire;
            if (push_fire) wr_ptr_d = wr_ptr_nxt;
            if (pop_fire)  rd_ptr_d = rd_ptr_nxt;
            if (push_fire && !pop_fire) begin
`ifdef BQ_DROP_OLDEST_EN
                // Full with no pop: the write lands on the oldest slot, so skip past it.
                if (full) begin
                    rd_ptr_d   = rd_ptr_nxt;
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
`else
                count_d = count_q + CNT_W'(1);
`endif
            end else if (pop_fire && !push_fire) begin
                count_d = count_q - CNT_W'(1);
            end
            if (bus.push_valid && !push_ready) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    bq_storage #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_storage (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.push_data),
        .rd_addr (rd_ptr_q),
        .rd_data (bus.pop_data)
    );

    assign bus.push_ready = push_ready;
    assign bus.pop_valid  = pop_valid;
    assign bus.count      = count_q;
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_bounded_queue_fifo.sv
// Directed-vector bench for bounded_queue_fifo (DATA_W=8, DEPTH=11); honours BQ_DROP_OLDEST_EN.
module tb_bounded_queue_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    bounded_queue_fifo_if #(.DATA_W(8), .DEPTH(11)) bus ();

    bounded_queue_fifo #(.DATA_W(8), .DEPTH(11)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        bus.push_valid = 1'b1;
        bus.push_data  = d;
        step();
        bus.push_valid = 1'b0;
    endtask

    task automatic pop_exp(input string tag, input logic [7:0] d);
        chk({tag, "_valid"}, 32'(bus.pop_valid), 32'd1);
        chk({tag, "_data"}, 32'(bus.pop_data), 32'(d));
        bus.pop_ready = 1'b1;
        step();
        bus.pop_ready = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
    endtask

    initial begin
        bus.clear      = 1'b0;
        bus.push_valid = 1'b0;
        bus.push_data  = '0;
        bus.pop_ready  = 1'b0;
        #1;

        // Reset state
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_push_ready", 32'(bus.push_ready), 32'd1);
        chk("rst_pop_valid", 32'(bus.pop_valid), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        step();
        rst = 1'b0;
        step();

        // Pop when empty changes nothing
        bus.pop_ready = 1'b1;
        step();
        bus.pop_ready = 1'b0;
        chk("empty_pop_count", 32'(bus.count), 32'd0);
        chk("empty_pop_empty", 32'(bus.empty), 32'd1);

        // Fill to DEPTH
        for (int i = 1; i <= 11; i++) push(8'(i));
        chk("fill_full", 32'(bus.full), 32'd1);
        chk("fill_count", 32'(bus.count), 32'd11);
        chk("fill_overflow", 32'(bus.overflow), 32'd0);
`ifdef BQ_DROP_OLDEST_EN
        chk("fill_push_ready", 32'(bus.push_ready), 32'd1);
        push(8'h0C);
        chk("drop_count", 32'(bus.count), 32'd11);
        chk("drop_overflow", 32'(bus.overflow), 32'd1);
        for (int i = 2; i <= 12; i++) pop_exp("drop_pop", 8'(i));
`else
        chk("fill_push_ready", 32'(bus.push_ready), 32'd0);
        push(8'hFF);
        chk("ovf_count", 32'(bus.count), 32'd11);
        chk("ovf_overflow", 32'(bus.overflow), 32'd1);
        for (int i = 1; i <= 11; i++) pop_exp("fill_pop", 8'(i));
`endif
        chk("drain_empty", 32'(bus.empty), 32'd1);
        chk("drain_count", 32'(bus.count), 32'd0);
        chk("drain_ovf_sticky", 32'(bus.overflow), 32'd1);
        do_clear();
        chk("clr_overflow", 32'(bus.overflow), 32'd0);

        // Wrap: advance pointers to 8, then push 10 so wr_ptr crosses 10 -> 0
        for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
        for (int i = 0; i < 8; i++) pop_exp("pre_wrap_pop", 8'h30 + 8'(i));
        for (int i = 0; i < 10; i++) push(8'hA0 + 8'(i));
        chk("wrap_count", 32'(bus.count), 32'd10);
        for (int i = 0; i < 10; i++) pop_exp("wrap_pop", 8'hA0 + 8'(i));
        chk("wrap_empty", 32'(bus.empty), 32'd1);

        // Simultaneous push/pop at count=5
        for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
        for (int i = 0; i < 20; i++) begin
            chk("sim_data", 32'(bus.pop_data),
                (i < 5) ? 32'h50 + 32'(i) : 32'h60 + 32'(i - 5));
            bus.push_valid = 1'b1;
            bus.push_data  = 8'h60 + 8'(i);
            bus.pop_ready  = 1'b1;
            step();
            chk("sim_count", 32'(bus.count), 32'd5);
        end
        bus.push_valid = 1'b0;
        bus.pop_ready  = 1'b0;
        for (int i = 15; i < 20; i++) pop_exp("sim_drain", 8'h60 + 8'(i));
        chk("sim_empty", 32'(bus.empty), 32'd1);

        // Clear wins over a same-cycle push
        for (int i = 0; i < 3; i++) push(8'h70 + 8'(i));
        bus.push_valid = 1'b1;
        bus.push_data  = 8'hEE;
        bus.clear      = 1'b1;
        step();
        bus.push_valid = 1'b0;
        bus.clear      = 1'b0;
        chk("clr_count", 32'(bus.count), 32'd0);
        chk("clr_empty", 32'(bus.empty), 32'd1);
        chk("clr_ovf", 32'(bus.overflow), 32'd0);
        chk("clr_pop_valid", 32'(bus.pop_valid), 32'd0);
        push(8'h33);
        pop_exp("post_clr_pop", 8'h33);

        // Asynchronous reset mid-operation
        push(8'h11);
        push(8'h22);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 32'(bus.count), 32'd0);
        chk("arst_empty", 32'(bus.empty), 32'd1);
        step();
        rst = 1'b0;
        step();
        chk("arst_pop_valid", 32'(bus.pop_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/bounded_queue_fifo.md
Name: bounded_queue_fifo

Overview:
- Parametrised bounded FIFO queue: first-word-fall-through, valid/ready push and pop interfaces, explicit occupancy count and sticky overflow status.
- Successor to the team's fixed 8-bit register-array buffer. Adds configurable width and depth (non-power-of-two allowed), full/empty tracking, true pop, flush.
- Sits between producer and consumer blocks in the datapath as an elastic buffer.

Parameters:
- DATA_W, 8, payload width in bits (>=1)
- DEPTH, 11, maximum entries held (>=2; need not be a power of two)
- CNT_W, $clog2(DEPTH+1), occupancy count width (derived, do not override)
- PTR_W, $clog2(DEPTH), pointer width (derived, do not override)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset: asynchronous, active-high
- clear  input  1  synchronous flush, empties queue and clears overflow flag
- push_valid  input  1  producer has data
- push_ready  output  1  queue accepts data this cycle
- push_data  input  DATA_W  write payload
- pop_valid  output  1  head entry valid
- pop_ready  input  1  consumer takes head this cycle
- pop_data  output  DATA_W  head entry (FWFT)
- count  output  CNT_W  current occupancy, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- overflow  output  1  sticky: a push was attempted while not accepted

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, overflow=0. Outputs: empty=1, full=0, pop_valid=0, push_ready=1. pop_data is don't-care; storage is not reset.
- push_fire = push_valid & push_ready. pop_fire = pop_valid & pop_ready.
- push_ready = !full (registered-state only; no combinational path from pop_ready). pop_valid = !empty.
- Write: on push_fire, store push_data at wr_ptr. Data is visible on pop_data the next cycle if the queue was empty (1-cycle latency).
- Read: pop_data = mem[rd_ptr] combinationally. On pop_fire, rd_ptr advances.
- Pointer wrap: a pointer equal to DEPTH-1 wraps to 0 explicitly. No modulo-2^PTR_W reliance.
- count: +1 on push_fire only, -1 on pop_fire only, unchanged on both or neither.
- Simultaneous push_fire and pop_fire: both pointers advance and count is held. When full, push is refused (push_ready=0) even if a pop occurs in the same cycle.
- Pop when empty: pop_valid=0, so no state change.
- overflow: set when push_valid & !push_ready. It stays set until clear or rst.
- clear: has priority over push/pop in the same cycle. Pointers, count and overflow go to 0. The push in that cycle is discarded and does not set overflow.
- Reset mid-operation: immediate return to reset state; queued contents are lost.

Optional Feature:
- Macro BQ_DROP_OLDEST_EN.
- Defined:
  - push_ready is tied to 1.
  - A push while full with no pop_fire writes at wr_ptr, advances wr_ptr and rd_ptr together, and holds count at DEPTH. The oldest entry is discarded and overflow is set.
  - A push while full with pop_fire behaves as a normal simultaneous push/pop and does not set overflow.
- Undefined: push is refused when full, as described in Behaviour.

Decomposition:
- Package bq_pkg: helper function next_ptr(ptr, depth) for explicit wrap, and default DATA_W/DEPTH localparams.
- Sub-module bq_storage: DEPTH x DATA_W register array with one write port and one async read port, no reset. The control/pointer logic stays in the top module.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, push_ready=1, pop_valid=0, overflow=0.
- Push 0x01..0x0B (11 words), no pops -> full=1, count=11, push_ready=0. Extra push of 0xFF -> overflow=1, count stays 11. Pops then return 0x01..0x0B in order, ending with empty=1.
- Wrap: push 8 and pop 8, then push 0xA0..0xA9 (10 words) -> wr_ptr crosses index 10 to 0. Pops return 0xA0..0xA9 in order.
- Simultaneous push/pop with count=5 for 20 cycles -> count stays 5 and data order is preserved.
- Push 3 words, assert clear together with push_valid -> next cycle count=0, empty=1, overflow=0, and the cleared push word is never popped.
- With BQ_DROP_OLDEST_EN: fill with 0x01..0x0B, then push 0x0C -> count=11, overflow=1, first pop returns 0x02.
